// File: rtl/spi_master_param.sv
// SPI master: one DATA_W-bit frame per request with per-frame CPOL/CPHA/bit order and decoded selects.
// Define SPI_MISO_CAPTURE_EN to enable the MISO receive path; otherwise rx_data stays 0.
module spi_master_param #(
    parameter int DATA_W  = 16,
    parameter int DIV     = 2,
    parameter int NUM_CS  = 1,
    localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic [5:0]        bit_count
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ECW = $clog2(2 * DATA_W + 1);
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [ECW-1:0] EDGE_LAST = ECW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [DCW-1:0]    div_cnt;
    logic [ECW-1:0]    edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] tx_next;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic [NUM_CS-1:0] cs_dec;
    logic              lead_edge;
    logic              sample_edge;
    logic              shift_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

`ifdef SPI_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_sh;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction
`else
    logic miso_unused;
    assign miso_unused = spi_miso;
`endif

    // Out-of-range selects decode to no active chip select; the frame still runs.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
        end
    end

    // Edge k = edge_cnt+1 is leading when odd; cpha picks which half samples vs shifts.
    assign lead_edge   = ~edge_cnt[0];
    assign sample_edge = lead_edge ^ cpha_q;
    assign shift_edge  = cpha_q ? (lead_edge && (edge_cnt != '0))
                                : (!lead_edge && (edge_cnt != EDGE_LAST));
    assign tx_next     = shift_out(tx_sh, lsb_q);
    assign busy        = ~tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx_ready  <= 1'b1;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            tx_sh     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            spi_cs_n  <= '1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_count <= '0;
`ifdef SPI_MISO_CAPTURE_EN
            rx_sh     <= '0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state     <= LEAD;
                        tx_ready  <= 1'b0;
                        div_cnt   <= '0;
                        tx_sh     <= tx_data;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        lsb_q     <= lsb_first;
                        spi_cs_n  <= cs_dec;
                        spi_sclk  <= cpol;
                        spi_mosi  <= first_bit(tx_data, lsb_first);
                        bit_count <= 6'(DATA_W);
                    end
                end
                LEAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= XFER;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_sclk <= ~spi_sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            bit_count <= bit_count - 6'd1;
`ifdef SPI_MISO_CAPTURE_EN
                            rx_sh <= shift_in(rx_sh, spi_miso, lsb_q);
`endif
                        end
                        if (shift_edge) begin
                            tx_sh    <= tx_next;
                            spi_mosi <= first_bit(tx_next, lsb_q);
                        end
                        if (edge_cnt == EDGE_LAST) state <= TRAIL;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        spi_cs_n <= '1;
                        spi_sclk <= cpol_q;
                        spi_mosi <= 1'b0;
                        rx_valid <= 1'b1;
`ifdef SPI_MISO_CAPTURE_EN
                        rx_data  <= rx_sh;
`endif
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
